uart_rx_pkt_ctrl: RTL and testbench

- Sequences the UART receiver's byte stream into framed command packets for the game controller.
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
- Payload is written into an external payload RAM and completion is handed to the host with a done/ack handshake.
- Detects bad length, checksum mismatch, inter-byte timeout and overrun.
- Sits between the UART receive path and the move decoder.

---
 rtl/uart_rx_pkt_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packet framer: SYNC, LEN, payload (to external RAM), CHK, with done/ack handoff.
// Optional statistics counters (good_cnt, err_cnt) are built when UART_RX_PKT_STATS_EN is defined.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         AW            = 4,
    parameter int         TIMEOUT_TICKS = 640,
    parameter int         TW            = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s_tick,
    input  logic          rx_byte_valid,
    input  logic [7:0]    rx_byte,
    output logic          pkt_wr,
    output logic [AW-1:0] pkt_waddr,
    output logic [7:0]    pkt_wdata,
    output logic          pkt_done,
    output logic [AW:0]   pkt_len,
    input  logic          pkt_ack,
    output logic          pkt_err,
    output logic [1:0]    err_code,
    output logic          overrun
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [7:0]    good_cnt,
    output logic [7:0]    err_cnt
`endif
);

    // state   | meaning
    // HUNT    | waiting for SYNC_BYTE, other bytes ignored
    // LEN     | expecting the length byte
    // PAYLOAD | writing payload bytes to RAM
    // CHK     | expecting the checksum byte
    // DONE    | good packet held for the host until pkt_ack
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DONE} state_t;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_TICKS);

    state_t         state, state_nxt;
    logic [AW:0]    len, len_nxt;
    logic [AW:0]    idx, idx_nxt, idx_inc;
    logic [7:0]     chk, chk_nxt;
    logic [TW-1:0]  tmr, tmr_nxt;
    logic           wr_nxt, done_nxt, err_nxt, ovr_nxt;
    logic [AW-1:0]  waddr_nxt;
    logic [7:0]     wdata_nxt;
    logic [AW:0]    plen_nxt;
    logic [1:0]     code_nxt;
    logic           in_frame, timeout_hit, done_entry;

    assign idx_inc = idx + 1'b1;

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        idx_nxt     = idx;
        chk_nxt     = chk;
        tmr_nxt     = tmr;
        wr_nxt      = 1'b0;
        waddr_nxt   = pkt_waddr;
        wdata_nxt   = pkt_wdata;
        done_nxt    = pkt_done;
        plen_nxt    = pkt_len;
        err_nxt     = 1'b0;
        code_nxt    = err_code;
        ovr_nxt     = overrun;
        done_entry  = 1'b0;
        in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CHK);

        // Down-counter reloads on every byte; a byte on the final tick wins.
        if (rx_byte_valid) begin
            tmr_nxt = TMR_LOAD;
        end else if (in_frame && s_tick && (tmr != '0)) begin
            tmr_nxt = tmr - 1'b1;
        end
        timeout_hit = in_frame && s_tick && !rx_byte_valid && (tmr == TW'(1));

        case (state)
            HUNT: begin
                if (rx_byte_valid && (rx_byte == SYNC_BYTE)) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (rx_byte_valid) begin
                    if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'b01;
                        state_nxt = HUNT;
                    end else begin
                        len_nxt   = rx_byte[AW:0];
                        chk_nxt   = rx_byte;
                        idx_nxt   = '0;
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_byte_valid) begin
                    wr_nxt    = 1'b1;
                    waddr_nxt = idx[AW-1:0];
                    wdata_nxt = rx_byte;
                    chk_nxt   = chk ^ rx_byte;
                    idx_nxt   = idx_inc;
                    if (idx_inc == len) begin
                        state_nxt = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_byte_valid) begin
                    if (rx_byte == chk) begin
                        done_nxt   = 1'b1;
                        plen_nxt   = len;
                        done_entry = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'b10;
                        state_nxt = HUNT;
                    end
                end
            end
            DONE: begin
                // A byte coinciding with the ack is simply dropped.
                if (pkt_ack) begin
                    done_nxt  = 1'b0;
                    ovr_nxt   = 1'b0;
                    plen_nxt  = '0;
                    state_nxt = HUNT;
                end else if (rx_byte_valid) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase

        if (timeout_hit) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b11;
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            len       <= '0;
            idx       <= '0;
            chk       <= '0;
            tmr       <= '0;
            pkt_wr    <= 1'b0;
            pkt_waddr <= '0;
            pkt_wdata <= '0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            chk       <= chk_nxt;
            tmr       <= tmr_nxt;
            pkt_wr    <= wr_nxt;
            pkt_waddr <= waddr_nxt;
            pkt_wdata <= wdata_nxt;
            pkt_done  <= done_nxt;
            pkt_len   <= plen_nxt;
            pkt_err   <= err_nxt;
            err_code  <= code_nxt;
            overrun   <= ovr_nxt;
        end
    end

`ifdef UART_RX_PKT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (done_entry && (good_cnt != 8'hFF)) begin
                good_cnt <= good_cnt + 1'b1;
            end
            if (err_nxt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: directed frames push expected RAM writes,
// errors and completions; a monitor pops and compares whenever the DUT presents one.
module tb_uart_rx_pkt_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_tick = 1'b0;
    logic          rx_byte_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          pkt_ack = 1'b0;
    logic          pkt_wr;
    logic [AW-1:0] pkt_waddr;
    logic [7:0]    pkt_wdata;
    logic          pkt_done;
    logic [AW:0]   pkt_len;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic          overrun;
`ifdef UART_RX_PKT_STATS_EN
    logic [7:0]    good_cnt;
    logic [7:0]    err_cnt;
`endif

    uart_rx_pkt_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_tick        (s_tick),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .pkt_wr        (pkt_wr),
        .pkt_waddr     (pkt_waddr),
        .pkt_wdata     (pkt_wdata),
        .pkt_done      (pkt_done),
        .pkt_len       (pkt_len),
        .pkt_ack       (pkt_ack),
        .pkt_err       (pkt_err),
        .err_code      (err_code),
        .overrun       (overrun)
`ifdef UART_RX_PKT_STATS_EN
        ,
        .good_cnt      (good_cnt),
        .err_cnt       (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam int K_WR = 1, K_ERR = 2, K_DONE = 3;
    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic done_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic take(input int kind, input int a, input int b, input string name);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got a=%0h b=%0h, required no event", name, a, b);
        end else begin
            e = sb.pop_front();
            if ((e.kind != kind) || (e.a != a) || (e.b != b)) begin
                n_bad++;
                $display("FAIL sb_%s: got kind=%0d a=%0h b=%0h, required kind=%0d a=%0h b=%0h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (pkt_wr)               take(K_WR, int'(pkt_waddr), int'(pkt_wdata), "wr");
            if (pkt_err)              take(K_ERR, int'(err_code), 0, "err");
            if (pkt_done && !done_q)  take(K_DONE, int'(pkt_len), 0, "done");
        end
        done_q = pkt_done;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b1;
        rx_byte       = b;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    endtask

    task automatic ack_pkt();
        @(posedge clk);
        #1 pkt_ack = 1'b1;
        @(posedge clk);
        #1 pkt_ack = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] frame16 [$];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({pkt_wr, pkt_waddr, pkt_wdata, pkt_done, pkt_len, pkt_err, err_code, overrun}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ack outside DONE is ignored
        ack_pkt();
        settle();
        check("ack_in_hunt_done", int'(pkt_done), 0);

        // Good frame: 03^11^22^33 = 03
        push(K_WR, 0, 'h11); push(K_WR, 1, 'h22); push(K_WR, 2, 'h33); push(K_DONE, 3, 0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h03);
        settle();
        check("good_done", int'(pkt_done), 1);
        check("good_len", int'(pkt_len), 3);
        ack_pkt();
        @(negedge clk);
        check("ack_clears_done", int'(pkt_done), 0);

        // Same payload with a checksum that omits LEN is rejected
        push(K_WR, 0, 'h11); push(K_WR, 1, 'h22); push(K_WR, 2, 'h33); push(K_ERR, 2, 0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h00);
        settle();

        // Bad checksum then a good frame
        push(K_WR, 0, 'h10); push(K_WR, 1, 'h20); push(K_ERR, 2, 0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        settle();
        check("badchk_done", int'(pkt_done), 0);
        check("badchk_code", int'(err_code), 2);
        push(K_WR, 0, 'h7E); push(K_DONE, 1, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        settle();
        check("after_badchk_len", int'(pkt_len), 1);
        ack_pkt();

        // Garbage then bad lengths 0 and 17
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        settle();
        check("garbage_code_held", int'(err_code), 2);
        push(K_ERR, 1, 0);
        send_byte(8'hA5); send_byte(8'h00);
        push(K_ERR, 1, 0);
        send_byte(8'hA5); send_byte(8'h11);
        settle();
        check("badlen_code", int'(err_code), 1);

        // Maximum length 16: 10 ^ (01^02^...^10) = 00
        for (int i = 0; i < 16; i++) begin
            frame16.push_back(8'(i + 1));
            push(K_WR, i, i + 1);
        end
        push(K_DONE, 16, 0);
        send_byte(8'hA5); send_byte(8'h10);
        foreach (frame16[i]) send_byte(frame16[i]);
        send_byte(8'h00);
        settle();
        check("max_len", int'(pkt_len), 16);
        ack_pkt();

        // Timeout after 640 ticks
        push(K_WR, 0, 'h44); push(K_ERR, 3, 0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        send_ticks(640);
        settle();
        check("timeout_code", int'(err_code), 3);

        // 639 ticks then a byte: no error; 02^44^55 = 13
        push(K_WR, 0, 'h44); push(K_WR, 1, 'h55); push(K_DONE, 2, 0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        send_ticks(639);
        send_byte(8'h55); send_byte(8'h13);
        settle();
        check("t639_done", int'(pkt_done), 1);

        // Overrun while DONE, cleared by ack
        send_byte(8'h55);
        settle();
        check("overrun_set", int'(overrun), 1);
        check("overrun_done_held", int'(pkt_done), 1);
        ack_pkt();
        @(negedge clk);
        check("overrun_cleared", int'({pkt_done, overrun}), 0);

        // Byte coinciding with ack is dropped without overrun
        push(K_WR, 0, 'h7E); push(K_DONE, 1, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        @(posedge clk);
        #1;
        pkt_ack = 1'b1; rx_byte_valid = 1'b1; rx_byte = 8'h55;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0; rx_byte_valid = 1'b0;
        @(negedge clk);
        check("ack_byte_overrun", int'({pkt_done, overrun}), 0);

        // Reset mid-frame
        push(K_WR, 0, 'h01);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              int'({pkt_wr, pkt_waddr, pkt_wdata, pkt_done, pkt_len, pkt_err, err_code, overrun}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(K_WR, 0, 'h09); push(K_DONE, 1, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09); send_byte(8'h08);
        settle();
        check("post_reset_done", int'(pkt_done), 1);
`ifdef UART_RX_PKT_STATS_EN
        check("good_cnt", int'(good_cnt), 1);
        check("err_cnt", int'(err_cnt), 0);
`endif
        ack_pkt();
        settle();

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
